// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver:
//   - uart_state_e   : frame state encoding (the same encoding on both sides)
//   - UART_DATA_BITS : data bits per frame
//   - UART_START_BIT / UART_STOP_BIT : serial line levels for the framing bits
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  // Codes 6 and 7 are unused; state machines map them back to IDLE.
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    TX_START_BIT  = 3'd1,
    TX_DATA_BITS  = 3'd2,
    TX_PARITY_BIT = 3'd3,
    TX_STOP_BIT   = 3'd4,
    CLEANUP       = 3'd5
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Counts clock cycles within one serial bit period and strobes on the last
// cycle of the bit. The receiver reuses it to time its own sampling points.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
// Ports:
//   i_Clock   in   sole clock, rising edge
//   i_Reset   in   synchronous, active-high reset
//   i_Enable  in   count while high; counter is held at 0 while low
//   o_Count   out  cycle index within the current bit, 0..CLKS_PER_BIT-1
//   o_Bit_End out  high on the last cycle of the bit (counter wraps to 0 next)
// -----------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic                            i_Clock,
  input  logic                            i_Reset,
  input  logic                            i_Enable,
  output logic [$clog2(CLKS_PER_BIT)-1:0] o_Count,
  output logic                            o_Bit_End
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign o_Bit_End = i_Enable && (count_q == CNT_LAST);
  assign o_Count   = count_q;

  // NOTE: combinational blocks assign every output on every path (here with a
  // single if/else) so synthesis never has to infer a latch to hold a value.
  always_comb begin
    if (!i_Enable || o_Bit_End) begin
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: clocked state is updated with non-blocking assignments only, so all
  // flops sample their inputs from the same edge regardless of block ordering.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : uart_bit_timer

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8-N-1 UART transmitter (8-x-1 with optional parity). A byte is accepted on
// any rising edge with i_TX_DV=1 while o_TX_Ready=1; it is then sent as a start
// bit, eight data bits LSB first, [parity bit], and a stop bit, each lasting
// CLKS_PER_BIT cycles, followed by one CLEANUP cycle that pulses o_TX_Done.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a parity bit is inserted between the data
//                      and stop bits (even parity, or odd when PARITY_ODD=1).
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   PARITY_ODD   : parity sense, 0 even / 1 odd (only with UART_TX_PARITY_EN)
// Ports:
//   i_Clock     in   sole clock, rising edge
//   i_Reset     in   synchronous, active-high reset; aborts any frame
//   i_TX_DV     in   send request, acted on only while o_TX_Ready=1
//   i_TX_Byte   in   data byte, sampled on the accepting edge only
//   o_TX_Ready  out  high in IDLE only
//   o_TX_Active out  high from start bit through stop bit
//   o_TX_Serial out  registered serial line, idles high
//   o_TX_Done   out  one-cycle pulse after the stop bit
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  idx_q, idx_d;
  logic        serial_q, serial_d;
  logic        ready_q, ready_d;
  logic        active_q, active_d;
  logic        done_q, done_d;

  logic        bit_end;
  logic [2:0]  idx_next;
  logic [$clog2(CLKS_PER_BIT)-1:0] unused_bit_count;

  // The timer runs exactly while a bit is on the line (start..stop), so it
  // sits at 0 in IDLE and CLEANUP and restarts cleanly at every frame.
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Enable (active_q),
    .o_Count  (unused_bit_count),
    .o_Bit_End(bit_end)
  );

  assign idx_next = idx_q + 3'd1;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;
  assign parity_bit = (^data_q) ^ (PARITY_ODD != 0);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  // Every output is registered: the next line level is decided together with
  // the state transition so o_TX_Serial changes exactly on bit boundaries.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    idx_d    = idx_q;
    serial_d = serial_q;
    ready_d  = ready_q;
    active_d = active_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        serial_d = UART_STOP_BIT;
        idx_d    = '0;
        ready_d  = 1'b1;
        active_d = 1'b0;
        if (i_TX_DV && ready_q) begin
          data_d   = i_TX_Byte;
          state_d  = TX_START_BIT;
          serial_d = UART_START_BIT;
          ready_d  = 1'b0;
          active_d = 1'b1;
        end
      end

      TX_START_BIT: begin
        if (bit_end) begin
          state_d  = TX_DATA_BITS;
          serial_d = data_q[0];
          idx_d    = '0;
        end
      end

      TX_DATA_BITS: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            idx_d    = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = TX_PARITY_BIT;
            serial_d = parity_bit;
`else
            state_d  = TX_STOP_BIT;
            serial_d = UART_STOP_BIT;
`endif
          end else begin
            idx_d    = idx_next;
            serial_d = data_q[idx_next];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      TX_PARITY_BIT: begin
        if (bit_end) begin
          state_d  = TX_STOP_BIT;
          serial_d = UART_STOP_BIT;
        end
      end
`endif

      TX_STOP_BIT: begin
        if (bit_end) begin
          state_d  = CLEANUP;
          serial_d = UART_STOP_BIT;
          active_d = 1'b0;
          done_d   = 1'b1;
        end
      end

      CLEANUP: begin
        state_d  = IDLE;
        serial_d = UART_STOP_BIT;
        ready_d  = 1'b1;
        active_d = 1'b0;
      end

      default: begin
        // Unused encodings (and the parity code in a no-parity build).
        state_d  = IDLE;
        serial_d = UART_STOP_BIT;
        idx_d    = '0;
        ready_d  = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      idx_q    <= '0;
      serial_q <= UART_STOP_BIT;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign o_TX_Ready  = ready_q;
  assign o_TX_Active = active_q;
  assign o_TX_Serial = serial_q;
  assign o_TX_Done   = done_q;

endmodule : uart_tx

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clock cycles per serial bit (i_Clock freq / baud); legal values >= 2.
REQ-002 SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only when UART_TX_PARITY_EN is defined.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Clock port is i_Clock and reset port is i_Reset.
REQ-004 i_Clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 i_Reset  input  1  synchronous, active-high reset.
REQ-006 i_TX_DV  input  1  request to send i_TX_Byte; acted on only while o_TX_Ready=1.
REQ-007 i_TX_Byte  input  8  data byte; sampled on the accepting edge only.
REQ-008 o_TX_Ready  output  1  high in IDLE only; a byte is accepted on any edge where i_TX_DV=1 and o_TX_Ready=1.
REQ-009 o_TX_Active  output  1  high from the start bit through the stop bit.
REQ-010 o_TX_Serial  output  1  serial line; idles high.
REQ-011 o_TX_Done  output  1  one-cycle pulse after the stop bit completes.

Function
REQ-012 States SHALL be IDLE, TX_START_BIT, TX_DATA_BITS, TX_PARITY_BIT (macro only), TX_STOP_BIT, CLEANUP; any unused encoding SHALL go to IDLE on the next edge.
REQ-013 IDLE: line=1, counter=0, bit index=0; on accept, latch the byte into an internal register and go to TX_START_BIT; changes to i_TX_Byte after accept SHALL be ignored.
REQ-014 i_TX_DV outside IDLE SHALL be ignored (no queueing); a byte is never dropped while accepted.
REQ-015 Each of start, data, parity and stop bits SHALL drive o_TX_Serial for exactly CLKS_PER_BIT cycles; start=0, stop=1.
REQ-016 Data bits SHALL be sent LSB first, index 0..7; index wraps to 0 on leaving TX_DATA_BITS.
REQ-017 Bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and clear on every bit boundary.
REQ-018 Latency: if accepted at edge 0, o_TX_Serial SHALL be 0 for cycles 1..CLKS_PER_BIT.
REQ-019 After the stop bit, the block SHALL spend 1 cycle in CLEANUP with line=1, o_TX_Done=1, o_TX_Active=0, then return to IDLE.
REQ-020 Minimum accept-to-accept interval SHALL be 10*CLKS_PER_BIT+2 cycles (11*CLKS_PER_BIT+2 with parity); i_TX_DV held high SHALL send back-to-back frames at this rate.
REQ-021 o_TX_Serial SHALL be registered (glitch-free) and SHALL never go low outside the start bit or a 0-valued data/parity bit.

Reset
REQ-022 i_Reset=1 SHALL force on the next edge: IDLE, o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0, counter=0, index=0, shift register=0.
REQ-023 Reset mid-frame SHALL abort the frame (line high on the next edge) and produce no o_TX_Done pulse; reset SHALL take priority over i_TX_DV.

Configuration
REQ-024 Macro UART_TX_PARITY_EN defined: TX_PARITY_BIT SHALL be inserted between the data and stop bits, with value ^byte (even) or ~^byte (PARITY_ODD=1); frame = 11 bits.
REQ-025 Macro undefined: no parity state or logic; frame = 10 bits; PARITY_ODD has no effect.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum (shared encoding with the receiver), UART_DATA_BITS=8, and start/stop bit level constants.
REQ-027 A single sub-module uart_bit_timer (counter plus bit-end strobe, parameterized by CLKS_PER_BIT) is natural and SHALL be reusable by the receiver.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-028 Reset, then i_TX_DV=1 with 0xA5 for 1 cycle -> line 0 x4, then 1,0,1,0,0,1,0,1 each x4, 1 x4; o_TX_Done pulses once at cycle 41.
REQ-029 i_TX_DV held high, bytes 0x00 then 0xFF -> two frames with accepts 42 cycles apart; data bits all 0, then all 1.
REQ-030 Second i_TX_DV pulse and i_TX_Byte change during the 0x3C frame -> the frame is unaltered and the second request is not sent.
REQ-031 i_Reset pulsed at cycle 15 of a frame -> line=1 and o_TX_Ready=1 on the next edge, no o_TX_Done, next accept sends a clean frame.
REQ-032 UART_TX_PARITY_EN defined: 0xA5 -> parity bit 0 (PARITY_ODD=0) or 1 (PARITY_ODD=1); 0x07 even -> 1; o_TX_Done at cycle 45.
REQ-033 CLKS_PER_BIT=217, 0x5A -> every bit lasts exactly 217 cycles; o_TX_Done at cycle 2171.
